// File: rtl/pwm_duty_meter.sv
// PWM on-time / period meter in 1 us ticks with stuck-line detection.
// Optional glitch filter enabled by defining PWM_METER_FILT_EN.
module pwm_duty_meter #(
    parameter logic [5:0]       CNT_1US_MAX = 6'd49,
    parameter int               CNT_W       = 11,
    parameter logic [CNT_W-1:0] TIMEOUT_US  = 11'd2000,
    parameter logic             ON_LEVEL    = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] on_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_US - 1);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             lvl;
    logic             on_edge;
    logic             off_edge;
    logic [5:0]       pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] on_lat;
    logic             timeout;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= ~ON_LEVEL;
            s2 <= ~ON_LEVEL;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

`ifdef PWM_METER_FILT_EN
    // Filtered level follows s2 only after 4 consecutive differing clocks
    logic       filt;
    logic [1:0] flt_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            filt    <= ~ON_LEVEL;
            flt_cnt <= 2'd0;
        end else if (s2 == filt) begin
            flt_cnt <= 2'd0;
        end else if (flt_cnt == 2'd3) begin
            filt    <= s2;
            flt_cnt <= 2'd0;
        end else begin
            flt_cnt <= flt_cnt + 2'd1;
        end
    end

    assign lvl = filt;
`else
    assign lvl = s2;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s3 <= ~ON_LEVEL;
        end else begin
            s3 <= lvl;
        end
    end

    assign on_edge  = (lvl == ON_LEVEL) && (s3 != ON_LEVEL);
    assign off_edge = (lvl != ON_LEVEL) && (s3 == ON_LEVEL);
    assign tick     = (pre_cnt == CNT_1US_MAX);
    // An on-edge in the same cycle always wins over the timeout
    assign timeout  = (state != IDLE) && tick && !on_edge &&
                      (tick_cnt == TO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= 6'd0;
        end else if (on_edge || tick) begin
            pre_cnt <= 6'd0;
        end else begin
            pre_cnt <= pre_cnt + 6'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt <= '0;
        end else if (on_edge) begin
            tick_cnt <= '0;
        end else if (tick && state != IDLE) begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            on_lat      <= '0;
            on_time     <= '0;
            period      <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (on_edge) begin
                        stuck <= 1'b0;
                        state <= ON;
                    end
                end
                ON: begin
                    if (timeout) begin
                        stuck       <= 1'b1;
                        stuck_level <= s2;
                        state       <= IDLE;
                    end else if (off_edge) begin
                        on_lat <= tick_cnt;
                        state  <= OFF;
                    end
                end
                OFF: begin
                    if (on_edge) begin
                        on_time    <= on_lat;
                        period     <= tick_cnt;
                        meas_valid <= 1'b1;
                        stuck      <= 1'b0;
                        state      <= ON;
                    end else if (timeout) begin
                        stuck       <= 1'b1;
                        stuck_level <= s2;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
